// File: rtl/i2c_master_byte_engine.sv
// Byte-level multi-master I2C master: START/WRITE/READ/STOP commands on open-drain SCL/SDA.
// Optional macro I2C_CLK_STRETCH_EN: after each SCL release the phase counter waits for SCL high.
module i2c_master_byte_engine #(
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_i,
  input  logic [7:0]       wr_byte_i,
  input  logic             rd_nack_i,
  output logic             rsp_valid_o,
  output logic [7:0]       rd_byte_o,
  output logic             ack_o,
  output logic             err_o,
  output logic             arb_lost_o,
  output logic             owner_o,
  output logic             bus_busy_o,
  output logic             scl_oe_o,
  output logic             sda_oe_o,
  input  logic             scl_i,
  input  logic             sda_i
);
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FREE, S_START, S_BIT, S_ACK, S_STOP, S_HOLD
  } state_t;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  logic [SYNC_STAGES-1:0] r_sclSync, r_sdaSync;
  logic                   r_sclPrev, r_sdaPrev;
  state_t                 r_state;
  logic [DIV_W-1:0]       r_div, r_cnt;
  logic [1:0]             r_phase;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic                   r_isRead, r_nack, r_ack;

  logic             w_scl, w_sda, w_startDet, w_stopDet;
  logic             w_accept, w_timed, w_hold, w_phaseEnd, w_stopChk;
  logic             w_sampleArb, w_busArb;
  logic [DIV_W-1:0] w_divIn;

  assign w_scl      = r_sclSync[SYNC_STAGES-1];
  assign w_sda      = r_sdaSync[SYNC_STAGES-1];
  assign w_startDet = r_sclPrev && w_scl && r_sdaPrev && !w_sda;
  assign w_stopDet  = r_sclPrev && w_scl && !r_sdaPrev && w_sda;
  assign w_accept   = cmd_valid_i && cmd_ready_o;
  assign w_divIn    = (clk_div_i == '0) ? DIV_W'(1) : clk_div_i;
  assign w_timed    = (r_state == S_START) || (r_state == S_BIT) ||
                      (r_state == S_ACK) || (r_state == S_STOP);

`ifdef I2C_CLK_STRETCH_EN
  assign w_hold = !w_scl && (((r_state == S_START) && (r_phase == 2'd0)) ||
                  (((r_state == S_BIT) || (r_state == S_ACK) || (r_state == S_STOP)) &&
                   (r_phase == 2'd1)));
`else
  assign w_hold = 1'b0;
`endif

  assign w_phaseEnd = w_timed && !w_hold && (r_cnt == r_div - 1'b1);
  // A very short quarter period cannot see the released SDA through the synchroniser before STOP ends.
  assign w_stopChk  = r_div > DIV_W'(SYNC_STAGES / 2);
  assign w_sampleArb = w_phaseEnd && !sda_oe_o && !w_sda &&
                       (((r_phase == 2'd2) && (r_state == S_BIT) && !r_isRead) ||
                        ((r_phase == 2'd2) && (r_state == S_ACK) && r_isRead) ||
                        ((r_phase == 2'd3) && (r_state == S_STOP) && w_stopChk));
  assign w_busArb    = owner_o && (r_state != S_STOP) && w_stopDet;

  // Pad synchronisers and bus-busy tracking from observed START/STOP conditions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sclSync  <= '1;
      r_sdaSync  <= '1;
      r_sclPrev  <= 1'b1;
      r_sdaPrev  <= 1'b1;
      bus_busy_o <= 1'b0;
    end else begin
      r_sclSync <= {r_sclSync[SYNC_STAGES-2:0], scl_i};
      r_sdaSync <= {r_sdaSync[SYNC_STAGES-2:0], sda_i};
      r_sclPrev <= w_scl;
      r_sdaPrev <= w_sda;
      if (w_startDet)     bus_busy_o <= 1'b1;
      else if (w_stopDet) bus_busy_o <= 1'b0;
    end
  end

  // Command FSM; each timed state walks four phases of D cycles per bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_cnt       <= '0;
      r_phase     <= 2'd0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_isRead    <= 1'b0;
      r_nack      <= 1'b0;
      r_ack       <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rd_byte_o   <= 8'h00;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
      arb_lost_o  <= 1'b0;
      owner_o     <= 1'b0;
      scl_oe_o    <= 1'b0;
      sda_oe_o    <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      arb_lost_o  <= 1'b0;
      if (w_timed) begin
        if (w_phaseEnd) begin
          r_cnt   <= '0;
          r_phase <= r_phase + 1'b1;
        end else if (!w_hold) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_sampleArb || w_busArb) begin
        r_state     <= S_IDLE;
        scl_oe_o    <= 1'b0;
        sda_oe_o    <= 1'b0;
        owner_o     <= 1'b0;
        rsp_valid_o <= 1'b1;
        arb_lost_o  <= 1'b1;
        cmd_ready_o <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_div   <= w_divIn;
              r_cnt   <= '0;
              r_phase <= 2'd0;
              if (cmd_i == CMD_START) begin
                cmd_ready_o <= 1'b0;
                r_state     <= bus_busy_o ? S_WAIT_FREE : S_START;
              end else begin
                rsp_valid_o <= 1'b1;
                err_o       <= 1'b1;
              end
            end
          end
          S_WAIT_FREE: begin
            if (!bus_busy_o) r_state <= S_START;
          end
          S_HOLD: begin
            if (w_accept) begin
              r_div       <= w_divIn;
              r_cnt       <= '0;
              r_phase     <= 2'd0;
              r_bit       <= 3'd0;
              cmd_ready_o <= 1'b0;
              r_shift     <= wr_byte_i;
              r_isRead    <= (cmd_i == CMD_READ);
              r_nack      <= rd_nack_i;
              case (cmd_i)
                CMD_START: begin r_state <= S_START; scl_oe_o <= 1'b0; end
                CMD_WRITE: begin r_state <= S_BIT;   sda_oe_o <= !wr_byte_i[7]; end
                CMD_READ:  begin r_state <= S_BIT;   sda_oe_o <= 1'b0; end
                default:   begin r_state <= S_STOP;  sda_oe_o <= 1'b1; end
              endcase
            end
          end
          S_START: begin
            if (w_phaseEnd) begin
              case (r_phase)
                2'd0: sda_oe_o <= 1'b1;
                2'd1: ;
                2'd2: scl_oe_o <= 1'b1;
                2'd3: begin
                  r_state     <= S_HOLD;
                  owner_o     <= 1'b1;
                  sda_oe_o    <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  cmd_ready_o <= 1'b1;
                end
              endcase
            end
          end
          S_BIT, S_ACK: begin
            if (w_phaseEnd) begin
              case (r_phase)
                2'd0: scl_oe_o <= 1'b0;
                2'd1: ;
                2'd2: begin
                  scl_oe_o <= 1'b1;
                  if (r_state == S_BIT) r_shift <= {r_shift[6:0], w_sda};
                  else                  r_ack   <= !w_sda;
                end
                2'd3: begin
                  if (r_state == S_ACK) begin
                    r_state     <= S_HOLD;
                    sda_oe_o    <= 1'b0;
                    rsp_valid_o <= 1'b1;
                    cmd_ready_o <= 1'b1;
                    ack_o       <= !r_isRead && r_ack;
                    if (r_isRead) rd_byte_o <= r_shift;
                  end else if (r_bit == 3'd7) begin
                    r_state  <= S_ACK;
                    sda_oe_o <= r_isRead && !r_nack;
                  end else begin
                    r_bit    <= r_bit + 1'b1;
                    sda_oe_o <= !r_isRead && !r_shift[7];
                  end
                end
              endcase
            end
          end
          S_STOP: begin
            if (w_phaseEnd) begin
              case (r_phase)
                2'd0: scl_oe_o <= 1'b0;
                2'd1: sda_oe_o <= 1'b0;
                2'd2: ;
                2'd3: begin
                  r_state     <= S_IDLE;
                  owner_o     <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  cmd_ready_o <= 1'b1;
                end
              endcase
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_byte_engine.sv
// Self-checking bench for i2c_master_byte_engine: directed and randomized command sequences
// against a transaction-level model of latencies, bus bits and responses.
module tb_i2c_master_byte_engine;
  localparam logic [1:0] C_START = 2'd0, C_WRITE = 2'd1, C_READ = 2'd2, C_STOP = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [15:0] clkDiv = 16'd4;
  logic        cmdValid = 1'b0;
  logic        cmdReady;
  logic [1:0]  cmd = 2'd0;
  logic [7:0]  wrByte = 8'h00;
  logic        rdNack = 1'b0;
  logic        rspValid;
  logic [7:0]  rdByte;
  logic        ack, err, arbLost, owner, busBusy, sclOe, sdaOe;
  logic        agentSdaLow = 1'b0;
  logic        manSdaLow = 1'b0;
  logic        manSclLow = 1'b0;
  logic        busScl, busSda;

  assign busScl = !(sclOe || manSclLow);
  assign busSda = !(sdaOe || agentSdaLow || manSdaLow);

  i2c_master_byte_engine dut (
    .clk_i(clk), .rst_i(rst), .clk_div_i(clkDiv),
    .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_i(cmd),
    .wr_byte_i(wrByte), .rd_nack_i(rdNack),
    .rsp_valid_o(rspValid), .rd_byte_o(rdByte), .ack_o(ack), .err_o(err),
    .arb_lost_o(arbLost), .owner_o(owner), .bus_busy_o(busBusy),
    .scl_oe_o(sclOe), .sda_oe_o(sdaOe), .scl_i(busScl), .sda_i(busSda)
  );

  // Bus agent: 0 idle, 1 write slave, 2 read slave, 3 competing master pulling SDA from bit 3 on.
  int         mode = 0;
  int         baseFall = 0, baseRise = 0;
  int         fallCnt = 0, riseCnt = 0;
  logic       prevScl = 1'b1;
  logic [7:0] wrCap = 8'h00;
  logic [7:0] slaveData = 8'h00;
  logic       slaveAck = 1'b0;
  logic       ninthOe = 1'b1;

  always @(posedge clk) begin : busAgent
    int nf, rr;
    nf = fallCnt + ((prevScl && !busScl) ? 1 : 0) - baseFall;
    rr = riseCnt + 1 - baseRise;
    prevScl <= busScl;
    if (prevScl && !busScl) fallCnt <= fallCnt + 1;
    if (!prevScl && busScl) begin
      riseCnt <= riseCnt + 1;
      if (mode == 1 && rr <= 8) wrCap <= {wrCap[6:0], busSda};
      if (mode == 2 && rr == 9) ninthOe <= sdaOe;
    end
    case (mode)
      1:       agentSdaLow <= (nf == 8) && slaveAck;
      2:       agentSdaLow <= (nf >= 0 && nf < 8) ? !slaveData[3'(7 - nf)] : 1'b0;
      3:       agentSdaLow <= (nf >= 3);
      default: agentSdaLow <= 1'b0;
    endcase
  end

  int total = 0;
  int bad = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int quarter(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic armAgent(input int m);
    @(negedge clk);
    mode     = m;
    baseFall = fallCnt;
    baseRise = riseCnt;
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] c, input logic [7:0] b,
                               input logic n, input int d);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, cmdReady}, 32'd1);
    cmd = c; wrByte = b; rdNack = n; clkDiv = 16'(d);
    cmdValid = 1'b1;
    @(posedge clk);
    #1 cmdValid = 1'b0;
  endtask

  task automatic waitRsp(input int limit, output int cyc);
    cyc = 1;
    while (!rspValid && cyc < limit) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!rspValid) cyc = 0;
  endtask

  task automatic runCmd(input string tag, input logic [1:0] c, input logic [7:0] b,
                        input logic n, input int d, input int expLat);
    int cyc;
    applyStimulus(tag, c, b, n, d);
    waitRsp(600, cyc);
    checkOutput({tag, "_lat"}, cyc, expLat);
  endtask

  task automatic doStart(input string tag, input int d);
    armAgent(0);
    runCmd(tag, C_START, 8'h00, 1'b0, d, 4 * quarter(d) + 1);
    checkOutput({tag, "_owner"}, {31'd0, owner}, 32'd1);
    checkOutput({tag, "_flags"}, {30'd0, err, arbLost}, 32'd0);
  endtask

  task automatic doStop(input string tag, input int d);
    armAgent(0);
    runCmd(tag, C_STOP, 8'h00, 1'b0, d, 4 * quarter(d) + 1);
    checkOutput({tag, "_owner"}, {31'd0, owner}, 32'd0);
    checkOutput({tag, "_flags"}, {30'd0, err, arbLost}, 32'd0);
    repeat (6) @(posedge clk);
    #1 checkOutput({tag, "_busy"}, {31'd0, busBusy}, 32'd0);
  endtask

  task automatic doWrite(input string tag, input logic [7:0] b, input logic sAck, input int d);
    slaveAck = sAck;
    armAgent(1);
    runCmd(tag, C_WRITE, b, 1'b0, d, 36 * quarter(d) + 1);
    checkOutput({tag, "_ack"}, {31'd0, ack}, {31'd0, sAck});
    checkOutput({tag, "_bits"}, {24'd0, wrCap}, {24'd0, b});
    checkOutput({tag, "_flags"}, {30'd0, err, arbLost}, 32'd0);
  endtask

  task automatic doRead(input string tag, input logic [7:0] sData, input logic n, input int d);
    slaveData = sData;
    armAgent(2);
    runCmd(tag, C_READ, 8'h00, n, d, 36 * quarter(d) + 1);
    checkOutput({tag, "_byte"}, {24'd0, rdByte}, {24'd0, sData});
    checkOutput({tag, "_ackbit"}, {31'd0, ninthOe}, {31'd0, !n});
    checkOutput({tag, "_flags"}, {30'd0, err, arbLost}, 32'd0);
  endtask

  task automatic doIllegal(input string tag, input logic [1:0] c, input int d);
    armAgent(0);
    runCmd(tag, c, 8'h5A, 1'b0, d, 1);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd1);
    checkOutput({tag, "_lines"}, {29'd0, sclOe, sdaOe, owner}, 32'd0);
  endtask

  initial begin
    int cyc, d, sawRsp;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'd0, cmdReady}, 32'd1);
    checkOutput("reset_lines", {30'd0, sclOe, sdaOe}, 32'd0);
    checkOutput("reset_outs", {27'd0, rspValid, err, arbLost, owner, busBusy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    doIllegal("idle_write", C_WRITE, 3);
    doIllegal("idle_read", C_READ, 0);
    doIllegal("idle_stop", C_STOP, 5);

    // Directed D=4 write and read transactions.
    doStart("d4_start", 4);
    checkOutput("d4_busy", {31'd0, busBusy}, 32'd1);
    doWrite("d4_write", 8'hA5, 1'b1, 4);
    doStop("d4_stop", 4);
    doStart("rd_start", 4);
    doRead("rd_3c", 8'h3C, 1'b1, 4);
    doStop("rd_stop", 4);

    // Randomized transactions with random quarter-period lengths.
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 5);
      doStart("rnd_start", d);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        d = $urandom_range(0, 5);
        if ($urandom_range(0, 1) == 1) doWrite("rnd_write", 8'($urandom), 1'($urandom), d);
        else                           doRead("rnd_read", 8'($urandom), 1'($urandom), d);
      end
      if ($urandom_range(0, 1) == 1) doStart("rnd_rstart", $urandom_range(1, 5));
      doStop("rnd_stop", $urandom_range(0, 5));
    end

    // Another master pulls SDA low from data bit 3 while we send 0xFF.
    doStart("arb_start", 4);
    armAgent(3);
    runCmd("arb_write", C_WRITE, 8'hFF, 1'b0, 4, (4 * 3 + 3) * 4 + 1);
    checkOutput("arb_lost", {31'd0, arbLost}, 32'd1);
    checkOutput("arb_lines", {29'd0, sclOe, sdaOe, owner}, 32'd0);
    armAgent(0);
    repeat (8) @(posedge clk);
    #1 checkOutput("arb_busy_clear", {30'd0, busBusy, cmdReady}, 32'd1);

    // External START holds the bus; our START waits until the external STOP.
    @(negedge clk);
    manSdaLow = 1'b1;
    repeat (6) @(posedge clk);
    #1 checkOutput("ext_busy", {31'd0, busBusy}, 32'd1);
    @(negedge clk);
    manSclLow = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus("ext_start", C_START, 8'h00, 1'b0, 3);
    sawRsp = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1 if (rspValid) sawRsp++;
    end
    checkOutput("ext_wait_rsp", sawRsp, 0);
    checkOutput("ext_wait_lines", {29'd0, sclOe, sdaOe, cmdReady}, 32'd0);
    @(negedge clk);
    manSclLow = 1'b0;
    repeat (3) @(negedge clk);
    manSdaLow = 1'b0;
    waitRsp(60, cyc);
    checkOutput("ext_start_rsp", {31'd0, cyc > 4 * 3}, 32'd1);
    checkOutput("ext_start_owner", {31'd0, owner}, 32'd1);
    doStop("ext_stop", 3);

    // Reset in the middle of a byte releases both lines at once.
    doStart("rst_start", 4);
    slaveAck = 1'b1;
    armAgent(1);
    applyStimulus("rst_write", C_WRITE, 8'h00, 1'b0, 4);
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_lines", {29'd0, sclOe, sdaOe, owner}, 32'd0);
    checkOutput("rst_ready", {31'd0, cmdReady}, 32'd1);
    mode = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 checkOutput("rst_idle", {28'd0, busBusy, rspValid, sclOe, sdaOe}, 32'd0);
    doIllegal("post_rst_write", C_WRITE, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
